mdu: RTL and testbench

//  Multiply/divide unit with HI/LO registers, placed between the register file read ports and the

---
 rtl/mdu_pkg.sv | 13 +
 rtl/mdu_arith.sv | 30 +++
 rtl/mdu.sv | 84 ++++++++
 tb/tb_mdu.sv | 124 ++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, widths, default latencies and FSM states for the multiply/divide unit.
package mdu_pkg;
  localparam int MDU_OP_W = 3;
  localparam logic [MDU_OP_W-1:0] MDU_MULT  = 3'd0;
  localparam logic [MDU_OP_W-1:0] MDU_MULTU = 3'd1;
  localparam logic [MDU_OP_W-1:0] MDU_DIV   = 3'd2;
  localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 3'd3;
  localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 3'd4;
  localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 3'd5;
  localparam int MDU_MUL_CYCLES = 5;
  localparam int MDU_DIV_CYCLES = 10;
  typedef enum logic {IDLE, RUN} mdu_state_e;
endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 32x32 multiply and divide producing HI/LO results and a divide-by-zero flag.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [MDU_OP_W-1:0] op,
  input  logic [31:0]         a,
  input  logic [31:0]         b,
  output logic [31:0]         res_hi,
  output logic [31:0]         res_lo,
  output logic                div_zero
);
  logic        sgn, is_div, a_neg, b_neg;
  logic [63:0] prod;
  logic [31:0] ma, mb, mb_nz, q, r;
  assign sgn    = (op == MDU_MULT) || (op == MDU_DIV);
  assign is_div = (op == MDU_DIV) || (op == MDU_DIVU);
  assign a_neg  = sgn & a[31];
  assign b_neg  = sgn & b[31];
  // Low 64 bits of the product of extended operands are correct for both signednesses
  assign prod   = {{32{a_neg}}, a} * {{32{b_neg}}, b};
  // Magnitude division keeps 0x80000000 / -1 well defined (quotient wraps to 0x80000000)
  assign ma     = a_neg ? -a : a;
  assign mb     = b_neg ? -b : b;
  assign div_zero = (b == 32'd0);
  assign mb_nz  = div_zero ? 32'd1 : mb;
  assign q      = ma / mb_nz;
  assign r      = ma % mb_nz;
  assign res_lo = is_div ? ((a_neg ^ b_neg) ? -q : q) : prod[31:0];
  assign res_hi = is_div ? (a_neg ? -r : r) : prod[63:32];
endmodule

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit with HI/LO registers, MTHI/MTLO and a stall flag.
module mdu
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = MDU_MUL_CYCLES,
  parameter int DIV_CYCLES = MDU_DIV_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MDU_OP_W-1:0] op,
  input  logic [31:0]         a,
  input  logic [31:0]         b,
  output logic                busy,
  output logic [31:0]         hi,
  output logic [31:0]         lo
);
  localparam int CW = $clog2((MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES) + 1);
  mdu_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        pend_dz_q, pend_dz_d;
  logic [31:0] res_hi, res_lo;
  logic        div_zero, is_md, is_div;
  mdu_arith u_arith (
    .op       (op),
    .a        (a),
    .b        (b),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );
  assign is_div = (op == MDU_DIV) || (op == MDU_DIVU);
  assign is_md  = (op == MDU_MULT) || (op == MDU_MULTU) || is_div;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_dz_d = pend_dz_q;
    if (state_q == IDLE) begin
      if (start && is_md) begin
        state_d   = RUN;
        cnt_d     = is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
        pend_hi_d = res_hi;
        pend_lo_d = res_lo;
        pend_dz_d = is_div && div_zero;
      end
      hi_d = (start && op == MDU_MTHI) ? a : hi_q;
      lo_d = (start && op == MDU_MTLO) ? a : lo_q;
    end else begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d = IDLE;
        hi_d    = pend_dz_q ? hi_q : pend_hi_q;
        lo_d    = pend_dz_q ? lo_q : pend_lo_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_dz_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_dz_q <= pend_dz_d;
    end
  end
  assign busy = (cnt_q != '0);
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed vector table plus hand sequences for busy-drop, reset abort and single-cycle latency.
module tb_mdu;
  import mdu_pkg::*;
  logic clk = 1'b0, reset, start, start1, busy, busy1;
  logic [2:0]  op;
  logic [31:0] a, b, hi, lo, hi1, lo1, ehi, elo;
  int checks = 0, errors = 0;
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    int          cyc;
  } vec_t;
  vec_t vecs[13];
  always #5 clk = ~clk;
  mdu u_dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .hi(hi), .lo(lo)
  );
  mdu #(.MUL_CYCLES(1), .DIV_CYCLES(1)) u_fast (
    .clk(clk), .reset(reset), .start(start1), .op(op), .a(a), .b(b),
    .busy(busy1), .hi(hi1), .lo(lo1)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic run_vec(input int idx, input vec_t v);
    int n = 0;
    start = 1'b1; op = v.op; a = v.a; b = v.b;
    @(negedge clk);
    start = 1'b0;
    while (busy && n < 50) begin
      chk($sformatf("v%0d hold_hi", idx), hi, ehi);
      chk($sformatf("v%0d hold_lo", idx), lo, elo);
      n++;
      @(negedge clk);
    end
    chk($sformatf("v%0d busy_cycles", idx), n, v.cyc);
    chk($sformatf("v%0d hi", idx), hi, v.hi);
    chk($sformatf("v%0d lo", idx), lo, v.lo);
    ehi = v.hi;
    elo = v.lo;
  endtask
  initial begin
    int n;
    vecs[0]  = '{MDU_MTHI,  32'h12345678, 32'h0,        32'h12345678, 32'h0,        0};
    vecs[1]  = '{MDU_DIVU,  32'd7,        32'h0,        32'h12345678, 32'h0,        10};
    vecs[2]  = '{MDU_MTLO,  32'hCAFEBABE, 32'h0,        32'h12345678, 32'hCAFEBABE, 0};
    vecs[3]  = '{3'd6,      32'h1,        32'h2,        32'h12345678, 32'hCAFEBABE, 0};
    vecs[4]  = '{MDU_MULT,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vecs[5]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
    vecs[6]  = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[7]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 10};
    vecs[8]  = '{MDU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       10};
    vecs[9]  = '{MDU_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
    vecs[10] = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};
    vecs[11] = '{MDU_MULTU, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        5};
    vecs[12] = '{MDU_DIV,   32'd0,        32'd0,        32'd1,        32'd0,        10};
    reset = 1'b1; start = 1'b0; start1 = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    reset = 1'b0;
    ehi = 32'd0;
    elo = 32'd0;
    @(negedge clk);
    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);
    // ops arriving while busy must be dropped
    start = 1'b1; op = MDU_DIVU; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 50) begin
      chk("busy_drop hold_hi", hi, ehi);
      chk("busy_drop hold_lo", lo, elo);
      n++;
      start = (n == 2) || (n == 4);
      op = (n == 2) ? MDU_MULT : MDU_MTLO;
      a = (n == 2) ? 32'd3 : 32'd55;
      b = 32'd3;
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy_drop cycles", n, 32'd10);
    chk("busy_drop hi", hi, 32'd2);
    chk("busy_drop lo", lo, 32'd14);
    // reset in the middle of a multiply abandons it
    start = 1'b1; op = MDU_MULT; a = 32'd7; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 3) begin
      n++;
      @(negedge clk);
    end
    chk("abort reached", n, 32'd3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy", {31'b0, busy}, 32'd0);
    chk("abort hi", hi, 32'd0);
    chk("abort lo", lo, 32'd0);
    repeat (8) @(negedge clk);
    chk("abort late busy", {31'b0, busy}, 32'd0);
    chk("abort late hi", hi, 32'd0);
    chk("abort late lo", lo, 32'd0);
    // single-cycle latency instance
    start1 = 1'b1; op = MDU_MULT; a = 32'd6; b = 32'd7;
    @(negedge clk);
    start1 = 1'b0;
    chk("fast busy1", {31'b0, busy1}, 32'd1);
    chk("fast hold_lo", lo1, 32'd0);
    @(negedge clk);
    chk("fast busy0", {31'b0, busy1}, 32'd0);
    chk("fast hi", hi1, 32'd0);
    chk("fast lo", lo1, 32'd42);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
